// File: rtl/tl_mem_responder.sv
// tl_mem_responder: TileLink manager endpoint serving uncached Acquires from a local 64-bit word memory; define TL_RESP_RELEASE_EN to add a Release channel
module tl_mem_responder #(
  parameter int DEPTH = 256,
  parameter int XACT_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_acquire_ready,
  input  logic              io_acquire_valid,
  input  logic [1:0]        io_acquire_bits_header_src,
  input  logic [1:0]        io_acquire_bits_header_dst,
  input  logic [25:0]       io_acquire_bits_payload_addr_block,
  input  logic              io_acquire_bits_payload_client_xact_id,
  input  logic [2:0]        io_acquire_bits_payload_addr_beat,
  input  logic              io_acquire_bits_payload_is_builtin_type,
  input  logic [2:0]        io_acquire_bits_payload_a_type,
  input  logic [11:0]       io_acquire_bits_payload_union,
  input  logic [63:0]       io_acquire_bits_payload_data,
  input  logic              io_grant_ready,
  output logic              io_grant_valid,
  output logic [1:0]        io_grant_bits_header_src,
  output logic [1:0]        io_grant_bits_header_dst,
  output logic [2:0]        io_grant_bits_payload_addr_beat,
  output logic              io_grant_bits_payload_client_xact_id,
  output logic [XACT_W-1:0] io_grant_bits_payload_manager_xact_id,
  output logic              io_grant_bits_payload_is_builtin_type,
  output logic [3:0]        io_grant_bits_payload_g_type,
  output logic [63:0]       io_grant_bits_payload_data,
  output logic              io_finish_ready,
  input  logic              io_finish_valid,
  input  logic [XACT_W-1:0] io_finish_bits_payload_manager_xact_id,
`ifdef TL_RESP_RELEASE_EN
  output logic              io_release_ready,
  input  logic              io_release_valid,
  input  logic [1:0]        io_release_bits_header_src,
  input  logic [1:0]        io_release_bits_header_dst,
  input  logic              io_release_bits_payload_client_xact_id,
  input  logic              io_release_bits_payload_voluntary,
`endif
  output logic              io_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, PUT_BEATS, GRANT, WAIT_FINISH} state_t;
  state_t state;
  logic [63:0] mem [DEPTH];
  logic [25:0] blk;
  logic [2:0] cnt, nxt;
  logic multi, rel_ack, acq_fire, grant_fire, finish_fire, is_put, we;
  logic [XACT_W-1:0] xact;
  logic [AW-1:0] aidx, waddr;
  logic [7:0] wmask;
  logic unused_union;

  // word index is {block, beat} truncated, so out-of-range addresses wrap
  function automatic logic [AW-1:0] idx(input logic [25:0] b, input logic [2:0] bt);
    return AW'({b, bt});
  endfunction

  assign acq_fire = io_acquire_ready && io_acquire_valid;
  assign grant_fire = io_grant_valid && io_grant_ready;
  assign finish_fire = io_finish_ready && io_finish_valid;
  assign is_put = io_acquire_bits_payload_is_builtin_type && io_acquire_bits_payload_a_type[2:1] == 2'b01;
  assign we = acq_fire && (state == PUT_BEATS || is_put);
  assign wmask = io_acquire_bits_payload_union[8:1];
  // block-type requests always start at beat 0; single-word requests use the given beat
  assign aidx = idx(io_acquire_bits_payload_addr_block, io_acquire_bits_payload_a_type[0] ? 3'd0 : io_acquire_bits_payload_addr_beat);
  assign waddr = state == PUT_BEATS ? idx(blk, cnt) : aidx;
  assign nxt = cnt + 3'd1;
  assign io_grant_bits_payload_manager_xact_id = xact;
  assign io_grant_bits_payload_is_builtin_type = 1'b1;
  assign unused_union = ^{io_acquire_bits_payload_union[11:9], io_acquire_bits_payload_union[0]};
`ifdef TL_RESP_RELEASE_EN
  assign io_release_ready = state == IDLE && io_acquire_ready && !io_acquire_valid;
`endif

  // byte-masked write port; contents are deliberately left unreset
  always_ff @(posedge clk)
    if (we)
      for (int i = 0; i < 8; i++)
        if (wmask[i]) mem[waddr][8*i +: 8] <= io_acquire_bits_payload_data[8*i +: 8];

  // transaction FSM with registered handshake outputs and grant bits
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      io_acquire_ready <= 1'b0;
      io_grant_valid <= 1'b0;
      io_finish_ready <= 1'b0;
      io_err <= 1'b0;
      xact <= '0;
      cnt <= 3'd0;
      blk <= 26'd0;
      multi <= 1'b0;
      rel_ack <= 1'b0;
      io_grant_bits_header_src <= 2'd0;
      io_grant_bits_header_dst <= 2'd0;
      io_grant_bits_payload_addr_beat <= 3'd0;
      io_grant_bits_payload_client_xact_id <= 1'b0;
      io_grant_bits_payload_g_type <= 4'd0;
      io_grant_bits_payload_data <= 64'd0;
    end else
      case (state)
        IDLE:
          if (acq_fire) begin
            blk <= io_acquire_bits_payload_addr_block;
            io_grant_bits_header_src <= io_acquire_bits_header_dst;
            io_grant_bits_header_dst <= io_acquire_bits_header_src;
            io_grant_bits_payload_client_xact_id <= io_acquire_bits_payload_client_xact_id;
            io_grant_bits_payload_addr_beat <= 3'd0;
            io_grant_bits_payload_data <= 64'd0;
            io_grant_bits_payload_g_type <= 4'd3;
            multi <= 1'b0;
            rel_ack <= 1'b0;
            cnt <= 3'd0;
            if (!io_acquire_bits_payload_is_builtin_type || io_acquire_bits_payload_a_type[2]) begin
              io_err <= 1'b1;
              io_acquire_ready <= 1'b0;
              io_grant_valid <= 1'b1;
              state <= GRANT;
            end else if (io_acquire_bits_payload_a_type[1:0] == 2'd3) begin
              cnt <= 3'd1;
              state <= PUT_BEATS;
            end else begin
              io_acquire_ready <= 1'b0;
              io_grant_valid <= 1'b1;
              state <= GRANT;
              if (!io_acquire_bits_payload_a_type[1]) begin
                multi <= io_acquire_bits_payload_a_type[0];
                io_grant_bits_payload_g_type <= io_acquire_bits_payload_a_type[0] ? 4'd5 : 4'd4;
                io_grant_bits_payload_addr_beat <= io_acquire_bits_payload_a_type[0] ? 3'd0 : io_acquire_bits_payload_addr_beat;
                io_grant_bits_payload_data <= mem[aidx];
              end
            end
          end
`ifdef TL_RESP_RELEASE_EN
          else if (io_release_ready && io_release_valid) begin
            if (io_release_bits_payload_voluntary) begin
              io_grant_bits_header_src <= io_release_bits_header_dst;
              io_grant_bits_header_dst <= io_release_bits_header_src;
              io_grant_bits_payload_client_xact_id <= io_release_bits_payload_client_xact_id;
              io_grant_bits_payload_addr_beat <= 3'd0;
              io_grant_bits_payload_data <= 64'd0;
              io_grant_bits_payload_g_type <= 4'd0;
              multi <= 1'b0;
              rel_ack <= 1'b1;
              io_acquire_ready <= 1'b0;
              io_grant_valid <= 1'b1;
              state <= GRANT;
            end else io_err <= 1'b1;
          end
`endif
          else io_acquire_ready <= 1'b1;
        PUT_BEATS:
          if (acq_fire) begin
            if (io_acquire_bits_payload_client_xact_id != io_grant_bits_payload_client_xact_id) io_err <= 1'b1;
            cnt <= nxt;
            if (cnt == 3'd7) begin
              cnt <= 3'd0;
              io_acquire_ready <= 1'b0;
              io_grant_valid <= 1'b1;
              state <= GRANT;
            end
          end
        GRANT:
          if (grant_fire) begin
            if (multi && cnt != 3'd7) begin
              cnt <= nxt;
              io_grant_bits_payload_addr_beat <= nxt;
              io_grant_bits_payload_data <= mem[idx(blk, nxt)];
            end else begin
              cnt <= 3'd0;
              io_grant_valid <= 1'b0;
              if (rel_ack) begin
                io_acquire_ready <= 1'b1;
                state <= IDLE;
              end else begin
                io_finish_ready <= 1'b1;
                state <= WAIT_FINISH;
              end
            end
          end
        WAIT_FINISH:
          if (finish_fire) begin
            if (io_finish_bits_payload_manager_xact_id != xact) io_err <= 1'b1;
            xact <= xact + 1'b1;
            io_finish_ready <= 1'b0;
            io_acquire_ready <= 1'b1;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_tl_mem_responder.sv
// tb_tl_mem_responder: table vectors, corner sequences and random traffic against a word-array reference model
module tb_tl_mem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0, reset = 1'b0;
  logic acquire_valid = 1'b0, a_cid = 1'b0, a_bi = 1'b0, grant_ready = 1'b0, finish_valid = 1'b0;
  logic [1:0] a_src = 2'd0, a_dst = 2'd0, f_id = 2'd0;
  logic [25:0] a_block = 26'd0;
  logic [2:0] a_beat = 3'd0, a_type = 3'd0;
  logic [11:0] a_union = 12'd0;
  logic [63:0] a_data = 64'd0;
  logic io_acquire_ready, io_grant_valid, g_cid_o, g_bi_o, io_finish_ready, io_err;
  logic [1:0] g_src_o, g_dst_o, g_xid_o;
  logic [2:0] g_beat_o;
  logic [3:0] g_type_o;
  logic [63:0] g_data_o;

  int errors = 0, checks = 0, g_n;
  logic [63:0] mref [DEPTH];
  logic [63:0] pb_data [8];
  logic [63:0] g_data [8];
  logic [2:0] g_beat [8];
  logic [3:0] g_type [8];
  logic [1:0] g_xid [8], g_src [8], g_dst [8];
  logic g_cid [8];
  logic [1:0] xid_m = 2'd0;
  logic err_m = 1'b0;

  typedef struct {
    logic [2:0] t;
    logic [25:0] blk;
    logic [2:0] bt;
    logic [7:0] m;
    logic [63:0] d;
    logic [3:0] eg;
    logic [63:0] ed;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  tl_mem_responder #(.DEPTH(DEPTH), .XACT_W(2)) dut (
    .clk(clk),
    .reset(reset),
    .io_acquire_ready(io_acquire_ready),
    .io_acquire_valid(acquire_valid),
    .io_acquire_bits_header_src(a_src),
    .io_acquire_bits_header_dst(a_dst),
    .io_acquire_bits_payload_addr_block(a_block),
    .io_acquire_bits_payload_client_xact_id(a_cid),
    .io_acquire_bits_payload_addr_beat(a_beat),
    .io_acquire_bits_payload_is_builtin_type(a_bi),
    .io_acquire_bits_payload_a_type(a_type),
    .io_acquire_bits_payload_union(a_union),
    .io_acquire_bits_payload_data(a_data),
    .io_grant_ready(grant_ready),
    .io_grant_valid(io_grant_valid),
    .io_grant_bits_header_src(g_src_o),
    .io_grant_bits_header_dst(g_dst_o),
    .io_grant_bits_payload_addr_beat(g_beat_o),
    .io_grant_bits_payload_client_xact_id(g_cid_o),
    .io_grant_bits_payload_manager_xact_id(g_xid_o),
    .io_grant_bits_payload_is_builtin_type(g_bi_o),
    .io_grant_bits_payload_g_type(g_type_o),
    .io_grant_bits_payload_data(g_data_o),
    .io_finish_ready(io_finish_ready),
    .io_finish_valid(finish_valid),
    .io_finish_bits_payload_manager_xact_id(f_id),
    .io_err(io_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int wi(input logic [25:0] b, input int bt);
    return int'((longint'(b) * 8 + longint'(bt)) % DEPTH);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] m);
    logic [63:0] r = o;
    for (int i = 0; i < 8; i++) if (m[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic send(input logic bi, input logic [2:0] t, input logic [25:0] blk, input logic [2:0] bt, input logic cid, input logic [7:0] m, input logic [63:0] d);
    int n = 0;
    acquire_valid = 1'b1; a_bi = bi; a_type = t; a_block = blk; a_beat = bt; a_cid = cid;
    a_union = {3'd0, m, 1'b0}; a_data = d; a_src = 2'd1; a_dst = 2'd2;
    while (!io_acquire_ready && n < 50) begin @(negedge clk); n++; end
    chk("acquire_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    acquire_valid = 1'b0;
  endtask

  task automatic collect();
    int n = 0;
    g_n = 0;
    grant_ready = 1'b1;
    while (io_grant_valid && n < 20) begin
      if (g_n < 8) begin
        g_data[g_n] = g_data_o; g_beat[g_n] = g_beat_o; g_type[g_n] = g_type_o;
        g_xid[g_n] = g_xid_o; g_cid[g_n] = g_cid_o; g_src[g_n] = g_src_o; g_dst[g_n] = g_dst_o;
      end
      g_n++; n++;
      @(negedge clk);
    end
    grant_ready = 1'b0;
  endtask

  task automatic fin(input logic [1:0] id);
    int n = 0;
    finish_valid = 1'b1; f_id = id;
    while (!io_finish_ready && n < 50) begin @(negedge clk); n++; end
    chk("finish_wait", 64'(n < 50), 64'd1);
    @(negedge clk);
    finish_valid = 1'b0;
  endtask

  task automatic xact(input logic bi, input logic [2:0] t, input logic [25:0] blk, input logic [2:0] bt, input logic [7:0] m, input logic [63:0] d, input bit fin_ok);
    bit ok;
    int nb;
    logic [3:0] eg;
    logic cid;
    ok = bi && t <= 3'd3;
    nb = (ok && t == 3'd1) ? 8 : 1;
    eg = !ok ? 4'd3 : t == 3'd0 ? 4'd4 : t == 3'd1 ? 4'd5 : 4'd3;
    cid = 1'($urandom_range(0, 1));
    if (ok && t == 3'd3) for (int i = 0; i < 8; i++) send(bi, t, blk, 3'(i), cid, m, pb_data[i]);
    else send(bi, t, blk, bt, cid, m, d);
    chk("grant_after_accept", 64'(io_grant_valid), 64'd1);
    collect();
    chk("beat_count", 64'(g_n), 64'(nb));
    for (int i = 0; i < nb && i < g_n; i++) begin
      chk("g_type", 64'(g_type[i]), 64'(eg));
      chk("xact_id", 64'(g_xid[i]), 64'(xid_m));
      chk("client_id", 64'(g_cid[i]), 64'(cid));
      chk("header", 64'({g_src[i], g_dst[i]}), 64'h9);
      if (ok && t <= 3'd1) begin
        chk("g_data", g_data[i], mref[wi(blk, t == 3'd1 ? i : int'(bt))]);
        chk("g_beat", 64'(g_beat[i]), 64'(t == 3'd1 ? i : int'(bt)));
      end else chk("ack_data", g_data[i], 64'd0);
    end
    if (ok && t == 3'd2) mref[wi(blk, int'(bt))] = merge(mref[wi(blk, int'(bt))], d, m);
    if (ok && t == 3'd3) for (int i = 0; i < 8; i++) mref[wi(blk, i)] = merge(mref[wi(blk, i)], pb_data[i], m);
    if (!ok) err_m = 1'b1;
    fin(fin_ok ? xid_m : xid_m + 2'd1);
    if (!fin_ok) err_m = 1'b1;
    xid_m = xid_m + 2'd1;
    chk("err_flag", 64'(io_err), 64'(err_m));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    xid_m = 2'd0;
    err_m = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [63:0] sd;
    logic [2:0] sb;
    tbl[0] = '{3'd2, 26'd0, 3'd5, 8'hFF, 64'h1122334455667788, 4'd3, 64'd0};
    tbl[1] = '{3'd0, 26'd0, 3'd5, 8'h00, 64'd0, 4'd4, 64'h1122334455667788};
    tbl[2] = '{3'd2, 26'd1, 3'd1, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 4'd3, 64'd0};
    tbl[3] = '{3'd2, 26'd1, 3'd1, 8'h0F, 64'd0, 4'd3, 64'd0};
    tbl[4] = '{3'd0, 26'd1, 3'd1, 8'h00, 64'd0, 4'd4, 64'hFFFFFFFF00000000};
    tbl[5] = '{3'd0, 26'd32, 3'd5, 8'h00, 64'd0, 4'd4, 64'h1122334455667788};
    tbl[6] = '{3'd2, 26'h3FFFFFF, 3'd7, 8'hFF, 64'hDEADBEEFCAFEF00D, 4'd3, 64'd0};
    tbl[7] = '{3'd0, 26'd31, 3'd7, 8'h00, 64'd0, 4'd4, 64'hDEADBEEFCAFEF00D};
    for (int i = 0; i < DEPTH; i++) mref[i] = 64'd0;

    repeat (3) @(negedge clk);
    chk("rst_acq_ready", 64'(io_acquire_ready), 64'd0);
    chk("rst_grant_valid", 64'(io_grant_valid), 64'd0);
    chk("rst_finish_ready", 64'(io_finish_ready), 64'd0);
    chk("rst_err", 64'(io_err), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_acq_ready", 64'(io_acquire_ready), 64'd1);
    chk("idle_xact_id", 64'(g_xid_o), 64'd0);

    for (int i = 0; i < 8; i++) begin
      xact(1'b1, tbl[i].t, tbl[i].blk, tbl[i].bt, tbl[i].m, tbl[i].d, 1'b1);
      chk("tbl_g_type", 64'(g_type[0]), 64'(tbl[i].eg));
      chk("tbl_data", g_data[0], tbl[i].ed);
    end

    for (int i = 0; i < 8; i++) pb_data[i] = 64'(i);
    xact(1'b1, 3'd3, 26'd2, 3'd0, 8'hFF, 64'd0, 1'b1);
    xact(1'b1, 3'd1, 26'd2, 3'd0, 8'h00, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("blk_data", g_data[i], 64'(i));
      chk("blk_beat", 64'(g_beat[i]), 64'(i));
      chk("blk_type", 64'(g_type[i]), 64'd5);
    end

    send(1'b1, 3'd0, 26'd0, 3'd5, 1'b0, 8'h00, 64'd0);
    sd = g_data_o;
    sb = g_beat_o;
    chk("stall_data0", sd, mref[5]);
    for (int k = 0; k < 4; k++) begin
      chk("stall_valid", 64'(io_grant_valid), 64'd1);
      chk("stall_data", g_data_o, sd);
      chk("stall_beat", 64'(g_beat_o), 64'(sb));
      chk("stall_acq_ready", 64'(io_acquire_ready), 64'd0);
      @(negedge clk);
    end
    collect();
    chk("stall_beats", 64'(g_n), 64'd1);
    chk("wait_fin_acq_ready", 64'(io_acquire_ready), 64'd0);
    fin(xid_m);
    xid_m = xid_m + 2'd1;
    chk("post_fin_acq_ready", 64'(io_acquire_ready), 64'd1);

    for (int b = 0; b < 32; b++) begin
      for (int i = 0; i < 8; i++) pb_data[i] = {$urandom, $urandom};
      xact(1'b1, 3'd3, 26'(b), 3'd0, 8'hFF, 64'd0, 1'b1);
    end
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < 8; i++) pb_data[i] = {$urandom, $urandom};
      xact(1'b1, 3'($urandom_range(0, 3)), 26'($urandom), 3'($urandom), 8'($urandom), {$urandom, $urandom}, 1'b1);
    end

    send(1'b1, 3'd1, 26'd2, 3'd0, 1'b0, 8'h00, 64'd0);
    grant_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_beat", 64'(g_beat_o), 64'd3);
    reset = 1'b0;
    #1;
    chk("async_rst_valid", 64'(io_grant_valid), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    grant_ready = 1'b0;
    @(negedge clk);
    chk("rst_idle_ready", 64'(io_acquire_ready), 64'd1);
    chk("rst_xact_id", 64'(g_xid_o), 64'd0);
    chk("rst_err_clear", 64'(io_err), 64'd0);
    xid_m = 2'd0;
    err_m = 1'b0;

    for (int k = 0; k < 5; k++) begin
      xact(1'b1, 3'd0, 26'd0, 3'd5, 8'h00, 64'd0, 1'b1);
      chk("xid_seq", 64'(g_xid[0]), 64'(k % 4));
    end
    xact(1'b1, 3'd0, 26'd0, 3'd5, 8'h00, 64'd0, 1'b0);
    chk("mismatch_err", 64'(io_err), 64'd1);

    do_reset();
    xact(1'b0, 3'd2, 26'd0, 3'd5, 8'hFF, {$urandom, $urandom}, 1'b1);
    chk("nonbuiltin_err", 64'(io_err), 64'd1);
    xact(1'b1, 3'd5, 26'd0, 3'd5, 8'hFF, 64'd0, 1'b1);
    xact(1'b1, 3'd0, 26'd0, 3'd5, 8'h00, 64'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tl_mem_responder.md
Name: tl_mem_responder

Overview:
- Manager-side TileLink endpoint. It terminates uncached Acquire traffic from a client-side enqueuer/crossbar port into a local word-addressed memory.
- It returns Grant beats and consumes Finish messages.
- It issues no probes, so there are no probe ports.
- It serves as the on-chip scratchpad / boot-RAM target behind the core's TileLink network.

Parameters:
- DEPTH, 256, number of 64-bit words; must be a power of two, at least 8.
- XACT_W, 2, width of the manager_xact_id counter.

Ports:
- clk input 1: single clock.
- reset input 1: asynchronous, active-low.
- io_acquire_ready output 1: Acquire accept.
- io_acquire_valid input 1: Acquire valid.
- io_acquire_bits_header_src / _dst input 2 each: routing header.
- io_acquire_bits_payload_addr_block input 26: block address.
- io_acquire_bits_payload_client_xact_id input 1: client transaction id.
- io_acquire_bits_payload_addr_beat input 3: beat within block.
- io_acquire_bits_payload_is_builtin_type input 1: built-in type flag.
- io_acquire_bits_payload_a_type input 3: 0 Get, 1 GetBlock, 2 Put, 3 PutBlock.
- io_acquire_bits_payload_union input 12: [8:1] byte write mask.
- io_acquire_bits_payload_data input 64: write data.
- io_grant_ready input 1: Grant accept.
- io_grant_valid output 1: Grant valid.
- io_grant_bits_header_src / _dst output 2 each: swapped Acquire header.
- io_grant_bits_payload_addr_beat output 3: beat index.
- io_grant_bits_payload_client_xact_id output 1: echoed client id.
- io_grant_bits_payload_manager_xact_id output XACT_W: current transaction id.
- io_grant_bits_payload_is_builtin_type output 1: constant 1.
- io_grant_bits_payload_g_type output 4: 0 voluntaryAck, 3 putAck, 4 getDataBeat, 5 getDataBlock.
- io_grant_bits_payload_data output 64: read data.
- io_finish_ready output 1: Finish accept.
- io_finish_valid input 1: Finish valid.
- io_finish_bits_payload_manager_xact_id input XACT_W: id being finished.
- io_err output 1: sticky protocol/type error flag.

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state IDLE;
  - all valids/readies 0, io_err 0;
  - xact counter 0, beat counter 0;
  - grant bit registers 0.
  - Memory contents are not reset.
- Word index = {addr_block, addr_beat} modulo DEPTH; out-of-range addresses wrap silently.
- States: IDLE, PUT_BEATS, GRANT, WAIT_FINISH.
- IDLE:
  - io_acquire_ready = 1. On handshake, latch header (src and dst swapped for Grant), client_xact_id, addr_block and type.
  - Get: read the word at the given addr_beat; go to GRANT with one beat, g_type 4. Grant data valid the cycle after accept (1-cycle latency).
  - GetBlock: go to GRANT with 8 beats, g_type 5. Beat i carries word {block, i}; grant addr_beat = i.
  - Put: write data under wmask in the accept cycle; go to GRANT with one putAck, data 0.
  - PutBlock: write beat 0 under wmask; beat counter = 1; go to PUT_BEATS.
  - is_builtin_type = 0 or a_type > 3: no memory effect; set io_err; go to GRANT with a putAck.
- PUT_BEATS:
  - io_acquire_ready = 1. Each accepted beat is written at {block, counter} under its own wmask; incoming addr_beat is ignored.
  - After the 8th beat, go to GRANT with a putAck.
  - Acquires with a different client_xact_id during PUT_BEATS set io_err but are still written.
- GRANT:
  - io_grant_valid = 1. Bits hold stable while valid && !ready.
  - Each handshake advances the beat; the next beat is presented in the following cycle (back-to-back when ready is held high).
  - After the final beat handshake, go to WAIT_FINISH.
- WAIT_FINISH:
  - io_finish_ready = 1. On handshake, the xact counter increments (wraps at 2^XACT_W) and state returns to IDLE.
  - A mismatched manager_xact_id is consumed and sets io_err.
- io_acquire_ready is 0 in GRANT and WAIT_FINISH. A finish arriving outside WAIT_FINISH is not accepted (ready 0).
- Only one transaction is in flight at a time.

Optional Feature:
- TL_RESP_RELEASE_EN defined adds these ports:
  - io_release_ready output 1;
  - io_release_valid input 1;
  - io_release_bits_header_src / _dst input 2 each;
  - io_release_bits_payload_client_xact_id input 1;
  - io_release_bits_payload_voluntary input 1.
- Release behaviour:
  - In IDLE, with no acquire valid (Acquire has priority), a release is accepted and its data discarded.
  - A voluntary release produces a single voluntaryAck Grant (g_type 0), then returns to IDLE with no Finish wait and no xact increment.
  - A non-voluntary release sets io_err and produces no Grant.
- TL_RESP_RELEASE_EN undefined: release ports are absent.

Test Plan:
- Put to word 5 with data 0x1122334455667788 and wmask 0xFF, then Get of word 5 -> putAck g_type 3, then getDataBeat returning 0x1122334455667788, grant valid one cycle after acquire accept.
- PutBlock on block 2 with beat data 0..7, then GetBlock on block 2 with grant_ready held high -> 8 consecutive grant cycles, addr_beat 0..7, data 0..7, g_type 5.
- Get with grant_ready low for 4 cycles -> grant bits stable for 4 cycles; acquire_ready stays 0 until the Finish handshake.
- Four transactions -> manager_xact_id 0,1,2,3, then 0; a Finish carrying id 2 while 1 is expected -> consumed, io_err = 1.
- Put with wmask 0x0F over 0xFFFFFFFFFFFFFFFF with data 0 -> subsequent Get returns 0xFFFFFFFF00000000.
- Reset asserted mid-GetBlock at beat 3 -> grant_valid 0 immediately; after release, IDLE with acquire_ready 1 and xact id 0.
